dit_frame_loader: RTL

DIT_FRAME_LOADER -- requirements
Module: dit_frame_loader

---
 rtl/dit_pkg.sv | 9 +
 rtl/dit_frame_loader.sv | 76 +++++++
 2 files changed

// File: rtl/dit_pkg.sv
// dit_pkg: shared FFT framing constants and the 4-point bit-reverse index table
package dit_pkg;
    localparam int SW_DEF = 4;
    localparam int FFT_N  = 4;
    localparam logic [1:0] BITREV_TAB [FFT_N] = '{2'd0, 2'd2, 2'd1, 2'd3};
    function automatic logic [1:0] bitrev_idx(input logic [1:0] k);
        return BITREV_TAB[k];
    endfunction
endpackage

// File: rtl/dit_frame_loader.sv
// dit_frame_loader: collects 4 serial samples into a registered frame for the 4-point FFT core
module dit_frame_loader
    import dit_pkg::*;
#(
    parameter int SW     = SW_DEF,
    parameter bit BITREV = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [SW-1:0] a,
    output logic [SW-1:0] b,
    output logic [SW-1:0] c,
    output logic [SW-1:0] d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    frame_cnt
);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] FULL = 1'b1;
    logic [0:0]    state;
    logic [1:0]    cnt;
    logic [SW-1:0] fbuf [FFT_N];
    logic [SW-1:0] smp  [FFT_N];
    logic [SW-1:0] frm  [FFT_N];
    logic          acc, last, free, load;
    assign in_ready = state == FILL;
    assign acc      = in_valid && in_ready;
    assign last     = acc && cnt == 2'd3;
    assign free     = !out_valid || out_ready;
    assign load     = (last && free) || (state == FULL && out_ready);
    // assemble the frame; in FILL the 4th sample comes straight from the input
    always_comb begin
        for (int k = 0; k < FFT_N; k++) smp[k] = fbuf[k];
        if (state == FILL) smp[FFT_N-1] = in_data;
        for (int k = 0; k < FFT_N; k++) frm[k] = smp[BITREV ? bitrev_idx(2'(k)) : 2'(k)];
    end
    // fill buffer and wrapping fill counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            for (int k = 0; k < FFT_N; k++) fbuf[k] <= '0;
        end else if (acc) begin
            fbuf[cnt] <= in_data;
            cnt       <= cnt + 2'd1;
        end
    end
    // FILL/FULL control: park in FULL while a completed frame waits for the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else if (state == FILL) state <= (last && !free) ? FULL : FILL;
        else state <= out_ready ? FILL : FULL;
    end
    // output register, valid flag and delivered-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            out_valid <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (load) begin
                a <= frm[0];
                b <= frm[1];
                c <= frm[2];
                d <= frm[3];
            end
            out_valid <= load ? 1'b1 : (out_ready ? 1'b0 : out_valid);
            if (out_valid && out_ready) frame_cnt <= frame_cnt + 8'd1;
        end
    end
endmodule
